// File: rtl/systolic_pkg.sv
// Shared types and constants for the 2x2 systolic array job sequencer.
// Matrices are packed row-major as {X22,X21,X12,X11}; elem_lsb() gives the
// bit offset of an element so every file slices them the same way.
package systolic_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 32;

  // FEED step on which each result diagonal is complete at the array outputs
  // (before any extra array pipeline latency is added).
  localparam int T_PUSH11   = 2;
  localparam int T_PUSHEDGE = 3;
  localparam int T_PUSH22   = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CLEAR  = 2'd1,
    S_FEED   = 2'd2,
    S_RESULT = 2'd3
  } sctrl_state_t;

  // Bit offset of element (row, col) in a packed 2x2 matrix of width-w entries.
  function automatic int elem_lsb(input int row, input int col, input int w);
    return ((row * 2) + col) * w;
  endfunction

endpackage

// File: rtl/systolic_ctrl_if.sv
// Host-side job interface of systolic_ctrl: operand handshake in, result
// handshake out. With SYSTOLIC_CTRL_ACCUM_EN defined an extra accum bit
// travels with the job and tells the controller to keep the accumulators.
interface systolic_ctrl_if
  import systolic_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
);

  logic                in_valid;
  logic                in_ready;
  logic [4*DATA_W-1:0] a_mat;
  logic [4*DATA_W-1:0] b_mat;
  logic                out_valid;
  logic                out_ready;
  logic [4*ACC_W-1:0]  c_mat;
`ifdef SYSTOLIC_CTRL_ACCUM_EN
  logic                accum;

  modport master (output in_valid, a_mat, b_mat, accum, out_ready,
                  input  in_ready, out_valid, c_mat);
  modport slave  (input  in_valid, a_mat, b_mat, accum, out_ready,
                  output in_ready, out_valid, c_mat);
`else
  modport master (output in_valid, a_mat, b_mat, out_ready,
                  input  in_ready, out_valid, c_mat);
  modport slave  (input  in_valid, a_mat, b_mat, out_ready,
                  output in_ready, out_valid, c_mat);
`endif

endinterface

// File: rtl/sctrl_skew_mux.sv
// Step-to-operand schedule for the 2x2 array. Row i of A enters at a<i>X and
// column j of B at bX<j>, each delayed by one step per row/column so the
// partial products meet in the right PE. Everything outside the schedule is 0.
module sctrl_skew_mux
  import systolic_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int T_W    = 3
) (
  input  logic                feed,
  input  logic [T_W-1:0]      t,
  input  logic [4*DATA_W-1:0] a_mat,
  input  logic [4*DATA_W-1:0] b_mat,
  output logic [DATA_W-1:0]   a1X,
  output logic [DATA_W-1:0]   a2X,
  output logic [DATA_W-1:0]   bX1,
  output logic [DATA_W-1:0]   bX2
);

  logic [DATA_W-1:0] a11, a12, a21, a22;
  logic [DATA_W-1:0] b11, b12, b21, b22;

  assign a11 = a_mat[elem_lsb(0, 0, DATA_W) +: DATA_W];
  assign a12 = a_mat[elem_lsb(0, 1, DATA_W) +: DATA_W];
  assign a21 = a_mat[elem_lsb(1, 0, DATA_W) +: DATA_W];
  assign a22 = a_mat[elem_lsb(1, 1, DATA_W) +: DATA_W];
  assign b11 = b_mat[elem_lsb(0, 0, DATA_W) +: DATA_W];
  assign b12 = b_mat[elem_lsb(0, 1, DATA_W) +: DATA_W];
  assign b21 = b_mat[elem_lsb(1, 0, DATA_W) +: DATA_W];
  assign b22 = b_mat[elem_lsb(1, 1, DATA_W) +: DATA_W];

  // Select the wavefront for the current step; idle steps drive zeros.
  always_comb begin
    a1X = '0;
    a2X = '0;
    bX1 = '0;
    bX2 = '0;
    if (feed) begin
      if (t == T_W'(0)) begin
        a1X = a11;
        bX1 = b11;
      end else if (t == T_W'(1)) begin
        a1X = a12;
        a2X = a21;
        bX1 = b21;
        bX2 = b12;
      end else if (t == T_W'(2)) begin
        a2X = a22;
        bX2 = b22;
      end
    end
  end

endmodule

// File: rtl/systolic_ctrl.sv
// Job sequencer for the 2x2 int8 systolic array: accepts an A/B pair, clears
// the array, feeds the skewed wavefronts, strobes each result diagonal into a
// holding register and offers the 2x2 product until the consumer takes it.
// Optional build macro: SYSTOLIC_CTRL_ACCUM_EN (accum bit skips CLEAR).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | in_ready high, waiting for a job
// CLEAR    | one cycle of array_clr before feeding
// FEED     | step counter t = 0 .. 4+PIPE_LAT drives operands and pushes
// RESULT   | out_valid high, c_mat held until out_ready
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ACC_W    = ACC_W_DEF,
  parameter int PIPE_LAT = 0
) (
  input  logic              clk,
  input  logic              reset,
  systolic_ctrl_if.slave    host,
  output logic              array_clr,
  output logic [DATA_W-1:0] a1X,
  output logic [DATA_W-1:0] a2X,
  output logic [DATA_W-1:0] bX1,
  output logic [DATA_W-1:0] bX2,
  output logic              push11,
  output logic              pushedge,
  output logic              push22,
  input  logic [ACC_W-1:0]  c11,
  input  logic [ACC_W-1:0]  c12,
  input  logic [ACC_W-1:0]  c21,
  input  logic [ACC_W-1:0]  c22,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE   = S_IDLE;
  localparam logic [1:0] ST_CLEAR  = S_CLEAR;
  localparam logic [1:0] ST_FEED   = S_FEED;
  localparam logic [1:0] ST_RESULT = S_RESULT;

  localparam int             T_W    = $clog2(T_PUSH22 + PIPE_LAT + 1);
  localparam logic [T_W-1:0] T_LAST = T_W'(T_PUSH22 + PIPE_LAT);

  logic [1:0]          state;
  logic [T_W-1:0]      t;
  logic [4*DATA_W-1:0] a_q;
  logic [4*DATA_W-1:0] b_q;
  logic [4*ACC_W-1:0]  c_q;
  logic                skip_clear;
  logic                feed;

`ifdef SYSTOLIC_CTRL_ACCUM_EN
  assign skip_clear = host.accum;
`else
  assign skip_clear = 1'b0;
`endif

  // Job sequencing: capture operands on acceptance, step through the schedule.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      t     <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (host.in_valid) begin
            a_q   <= host.a_mat;
            b_q   <= host.b_mat;
            t     <= '0;
            state <= skip_clear ? ST_FEED : ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          t     <= '0;
          state <= ST_FEED;
        end
        ST_FEED: begin
          if (t == T_LAST) begin
            state <= ST_RESULT;
          end else begin
            t <= t + 1'b1;
          end
        end
        ST_RESULT: begin
          if (host.out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign feed      = (state == ST_FEED);
  assign push11    = feed && (t == T_W'(T_PUSH11 + PIPE_LAT));
  assign pushedge  = feed && (t == T_W'(T_PUSHEDGE + PIPE_LAT));
  assign push22    = feed && (t == T_W'(T_PUSH22 + PIPE_LAT));
  assign array_clr = (state == ST_CLEAR);
  assign busy      = (state != ST_IDLE);

  assign host.in_ready  = (state == ST_IDLE);
  assign host.out_valid = (state == ST_RESULT);
  assign host.c_mat     = c_q;

  // Latch each result diagonal on its push strobe; values pass through untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_q <= '0;
    end else begin
      if (push11) begin
        c_q[elem_lsb(0, 0, ACC_W) +: ACC_W] <= c11;
      end
      if (pushedge) begin
        c_q[elem_lsb(0, 1, ACC_W) +: ACC_W] <= c12;
        c_q[elem_lsb(1, 0, ACC_W) +: ACC_W] <= c21;
      end
      if (push22) begin
        c_q[elem_lsb(1, 1, ACC_W) +: ACC_W] <= c22;
      end
    end
  end

  sctrl_skew_mux #(
    .DATA_W (DATA_W),
    .T_W    (T_W)
  ) u_skew (
    .feed   (feed),
    .t      (t),
    .a_mat  (a_q),
    .b_mat  (b_q),
    .a1X    (a1X),
    .a2X    (a2X),
    .bX1    (bX1),
    .bX2    (bX2)
  );

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: two controllers (PIPE_LAT 0 and 2), each driving a
// behavioural 2x2 output-stationary array. Expected products come from a
// direct matrix multiply and are queued when a job is offered.
module tb_systolic_ctrl;

  logic clk;
  logic reset;

  logic        iv     [2];
  logic [31:0] am     [2];
  logic [31:0] bm     [2];
  logic        ordy   [2];
  logic        acc_in [2];

  logic         in_rdy [2];
  logic         o_vld  [2];
  logic [127:0] cm     [2];

  logic       array_clr [2];
  logic [7:0] a1x [2];
  logic [7:0] a2x [2];
  logic [7:0] bx1 [2];
  logic [7:0] bx2 [2];
  logic       p11 [2];
  logic       pe  [2];
  logic       p22 [2];
  logic       busy [2];

  int acc [2][4];
  int d1  [2][4];
  int d2  [2][4];
  logic [7:0] ap11 [2];
  logic [7:0] ap21 [2];
  logic [7:0] bp11 [2];
  logic [7:0] bp12 [2];

  systolic_ctrl_if ifc0 ();
  systolic_ctrl_if ifc1 ();

  assign ifc0.in_valid  = iv[0];
  assign ifc0.a_mat     = am[0];
  assign ifc0.b_mat     = bm[0];
  assign ifc0.out_ready = ordy[0];
  assign ifc1.in_valid  = iv[1];
  assign ifc1.a_mat     = am[1];
  assign ifc1.b_mat     = bm[1];
  assign ifc1.out_ready = ordy[1];
`ifdef SYSTOLIC_CTRL_ACCUM_EN
  assign ifc0.accum = acc_in[0];
  assign ifc1.accum = acc_in[1];
`endif
  assign in_rdy[0] = ifc0.in_ready;
  assign in_rdy[1] = ifc1.in_ready;
  assign o_vld[0]  = ifc0.out_valid;
  assign o_vld[1]  = ifc1.out_valid;
  assign cm[0]     = ifc0.c_mat;
  assign cm[1]     = ifc1.c_mat;

  systolic_ctrl #(.PIPE_LAT(0)) u_dut0 (
    .clk(clk), .reset(reset), .host(ifc0), .array_clr(array_clr[0]),
    .a1X(a1x[0]), .a2X(a2x[0]), .bX1(bx1[0]), .bX2(bx2[0]),
    .push11(p11[0]), .pushedge(pe[0]), .push22(p22[0]),
    .c11(acc[0][0]), .c12(acc[0][1]), .c21(acc[0][2]), .c22(acc[0][3]),
    .busy(busy[0])
  );

  systolic_ctrl #(.PIPE_LAT(2)) u_dut1 (
    .clk(clk), .reset(reset), .host(ifc1), .array_clr(array_clr[1]),
    .a1X(a1x[1]), .a2X(a2x[1]), .bX1(bx1[1]), .bX2(bx2[1]),
    .push11(p11[1]), .pushedge(pe[1]), .push22(p22[1]),
    .c11(d2[1][0]), .c12(d2[1][1]), .c21(d2[1][2]), .c22(d2[1][3]),
    .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int mul8(input logic signed [7:0] x, input logic signed [7:0] y);
    return int'(x) * int'(y);
  endfunction

  // Behavioural array: operands hop right/down one PE per cycle; instance 1
  // sees its results through two extra pipeline stages.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (array_clr[i]) begin
        for (int k = 0; k < 4; k++) acc[i][k] <= 0;
        ap11[i] <= '0;
        ap21[i] <= '0;
        bp11[i] <= '0;
        bp12[i] <= '0;
      end else begin
        acc[i][0] <= acc[i][0] + mul8(a1x[i], bx1[i]);
        acc[i][1] <= acc[i][1] + mul8(ap11[i], bx2[i]);
        acc[i][2] <= acc[i][2] + mul8(a2x[i], bp11[i]);
        acc[i][3] <= acc[i][3] + mul8(ap21[i], bp12[i]);
        ap11[i] <= a1x[i];
        ap21[i] <= a2x[i];
        bp11[i] <= bx1[i];
        bp12[i] <= bx2[i];
      end
      for (int k = 0; k < 4; k++) begin
        d1[i][k] <= acc[i][k];
        d2[i][k] <= d1[i][k];
      end
    end
  end

  typedef struct {
    logic [127:0] c;
    int           lat;
  } sb_t;

  typedef struct {
    logic         in_ready, out_valid, busy, clr, p11, pe, p22;
    logic [31:0]  ops;
    logic [127:0] c;
  } obs_t;

  sb_t          sb [$];
  logic [127:0] prev_c [2];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic obs_t sample(input int i);
    obs_t o;
    o.in_ready  = in_rdy[i];
    o.out_valid = o_vld[i];
    o.busy      = busy[i];
    o.clr       = array_clr[i];
    o.p11       = p11[i];
    o.pe        = pe[i];
    o.p22       = p22[i];
    o.ops       = {a1x[i], a2x[i], bx1[i], bx2[i]};
    o.c         = cm[i];
    return o;
  endfunction

  function automatic int pl_of(input int i);
    return (i == 0) ? 0 : 2;
  endfunction

  function automatic logic [31:0] pack4(input int x11, input int x12, input int x21, input int x22);
    return {8'(x22), 8'(x21), 8'(x12), 8'(x11)};
  endfunction

  function automatic int el(input logic [31:0] m, input int idx);
    logic signed [7:0] x;
    x = m[idx*8 +: 8];
    return int'(x);
  endfunction

  function automatic logic [127:0] matmul(input logic [31:0] a, input logic [31:0] b);
    int c11, c12, c21, c22;
    c11 = el(a, 0) * el(b, 0) + el(a, 1) * el(b, 2);
    c12 = el(a, 0) * el(b, 1) + el(a, 1) * el(b, 3);
    c21 = el(a, 2) * el(b, 0) + el(a, 3) * el(b, 2);
    c22 = el(a, 2) * el(b, 1) + el(a, 3) * el(b, 3);
    return {32'(c22), 32'(c21), 32'(c12), 32'(c11)};
  endfunction

  function automatic logic [127:0] add_c(input logic [127:0] x, input logic [127:0] y);
    logic [127:0] r;
    for (int k = 0; k < 4; k++) r[k*32 +: 32] = x[k*32 +: 32] + y[k*32 +: 32];
    return r;
  endfunction

  // {a1X,a2X,bX1,bX2} expected on feed step s
  function automatic logic [31:0] exp_ops(input logic [31:0] a, input logic [31:0] b, input int s);
    case (s)
      0:       return {a[7:0], 8'h00, b[7:0], 8'h00};
      1:       return {a[15:8], a[23:16], b[23:16], b[15:8]};
      2:       return {8'h00, a[31:24], 8'h00, b[31:24]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic check_rst(input string tag, input int i);
    obs_t o;
    o = sample(i);
    check({tag, ".in_ready"}, 128'(o.in_ready), 128'(1));
    check({tag, ".out_valid"}, 128'(o.out_valid), 128'(0));
    check({tag, ".busy"}, 128'(o.busy), 128'(0));
    check({tag, ".clr"}, 128'(o.clr), 128'(0));
    check({tag, ".push"}, 128'({o.p11, o.pe, o.p22}), 128'(0));
    check({tag, ".ops"}, 128'(o.ops), 128'(0));
    check({tag, ".c_mat"}, o.c, 128'(0));
  endtask

  task automatic do_job(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic accum, input int hold, input string tag);
    sb_t  e, got;
    obs_t o;
    int   off, lat, n11, ne, n22, k11, ke, k22, nclr;
    off   = accum ? 1 : 2;
    e.c   = matmul(a, b);
    if (accum) e.c = add_c(prev_c[i], e.c);
    e.lat = off + 5 + pl_of(i);
    prev_c[i] = e.c;
    sb.push_back(e);
    @(negedge clk);
    o = sample(i);
    check({tag, ".in_ready"}, 128'(o.in_ready), 128'(1));
    iv[i] = 1'b1;
    am[i] = a;
    bm[i] = b;
    acc_in[i] = accum;
    ordy[i] = (hold == 0);
    lat = -1; n11 = -1; ne = -1; n22 = -1;
    k11 = 0; ke = 0; k22 = 0; nclr = 0;
    @(posedge clk);
    for (int n = 1; n <= 24 && lat < 0; n++) begin
      @(negedge clk);
      iv[i] = 1'b0;
      o = sample(i);
      if (o.clr) nclr++;
      if (o.p11) begin k11++; n11 = n; end
      if (o.pe)  begin ke++;  ne  = n; end
      if (o.p22) begin k22++; n22 = n; end
      if (n >= off && n <= off + 3)
        check($sformatf("%s.ops_t%0d", tag, n - off), 128'(o.ops), 128'(exp_ops(a, b, n - off)));
      if (o.out_valid) lat = n;
    end
    got = sb.pop_front();
    check({tag, ".latency"}, 128'(lat), 128'(got.lat));
    check({tag, ".c_mat"}, o.c, got.c);
    check({tag, ".clr_pulses"}, 128'(nclr), 128'(accum ? 0 : 1));
    check({tag, ".push11_at"}, 128'(n11), 128'(off + 2 + pl_of(i)));
    check({tag, ".pushedge_at"}, 128'(ne), 128'(off + 3 + pl_of(i)));
    check({tag, ".push22_at"}, 128'(n22), 128'(off + 4 + pl_of(i)));
    check({tag, ".push_counts"}, 128'({8'(k11), 8'(ke), 8'(k22)}), 128'(24'h010101));
    for (int k = 0; k < hold; k++) begin
      iv[i] = 1'b1;
      am[i] = ~a;
      bm[i] = ~b;
      @(negedge clk);
      o = sample(i);
      check({tag, ".hold_valid"}, 128'(o.out_valid), 128'(1));
      check({tag, ".hold_c"}, o.c, got.c);
      check({tag, ".hold_in_ready"}, 128'(o.in_ready), 128'(0));
    end
    iv[i] = 1'b0;
    acc_in[i] = 1'b0;
    ordy[i] = 1'b1;
    @(negedge clk);
    ordy[i] = 1'b0;
    o = sample(i);
    check({tag, ".done_valid"}, 128'(o.out_valid), 128'(0));
    check({tag, ".done_idle"}, 128'({o.in_ready, o.busy}), 128'(2'b10));
  endtask

  initial begin
    logic [31:0] ra, rb, ext, idm, bb;
    obs_t o;
    ra  = pack4(-6, 7, 1, -4);
    rb  = pack4(-2, 0, 9, 1);
    ext = pack4(-128, -128, -128, -128);
    idm = pack4(1, 0, 0, 1);
    bb  = pack4(3, 4, 5, 6);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      iv[i] = 1'b0; am[i] = '0; bm[i] = '0; ordy[i] = 1'b0; acc_in[i] = 1'b0;
      prev_c[i] = '0;
    end
    @(negedge clk);
    check_rst("reset0", 0);
    check_rst("reset1", 1);
    reset = 1'b1;

    do_job(0, ra, rb, 1'b0, 0, "ref");
    check("ref.literal", cm[0], {32'(-4), 32'(-38), 32'(7), 32'(75)});

    do_job(0, pack4(5, -6, 7, 8), pack4(1, 2, 3, 4), 1'b0, 10, "backpressure");
    do_job(0, ext, ext, 1'b0, 0, "extremes");
    check("extremes.literal", cm[0], {4{32'd32768}});

    // abort a job at t=1 with reset, then run a clean one
    @(negedge clk);
    iv[0] = 1'b1; am[0] = ra; bm[0] = rb;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    o = sample(0);
    check("midreset.pre_busy", 128'(o.busy), 128'(1));
    #2 reset = 1'b0;
    #1 check_rst("midreset", 0);
    @(negedge clk);
    reset = 1'b1;
    do_job(0, idm, bb, 1'b0, 0, "after_reset");
    check("after_reset.literal", cm[0], {32'd6, 32'd5, 32'd4, 32'd3});

    do_job(1, ra, rb, 1'b0, 0, "pipe_lat2");

`ifdef SYSTOLIC_CTRL_ACCUM_EN
    do_job(0, ra, rb, 1'b0, 0, "accum_first");
    do_job(0, ra, rb, 1'b1, 0, "accum_second");
    check("accum.literal", cm[0], {32'(-8), 32'(-76), 32'(14), 32'(150)});
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/systolic_ctrl.md
# systolic_ctrl

Job sequencer for the 2x2 int8 systolic array `systolic_matrix`.
- Accepts a complete A/B operand pair over a valid/ready handshake.
- Clears the array, drives the skewed operand wavefronts onto `a1X`/`a2X`/`bX1`/`bX2`, and pulses `push11`/`pushedge`/`push22` as each result diagonal completes.
- Captures `c11`..`c22` and returns the 2x2 int32 product over a second valid/ready handshake.
- Sits between the host-side register/DMA logic and the array.

## Interface
- DATA_W, 8, operand width (signed)
- ACC_W, 32, accumulator/result width (signed)
- PIPE_LAT, 0, extra array latency cycles inserted before each push strobe
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset (low = reset)
- in_valid  input  1  job offered
- in_ready  output  1  controller can accept job
- a_mat  input  4*DATA_W  {A22,A21,A12,A11}, row-major, signed
- b_mat  input  4*DATA_W  {B22,B21,B12,B11}
- out_valid  output  1  result held
- out_ready  input  1  consumer takes result
- c_mat  output  4*ACC_W  {C22,C21,C12,C11}
- array_clr  output  1  active-high clear to array accumulators
- a1X, a2X, bX1, bX2  output  DATA_W each  array operand ports
- push11, pushedge, push22  output  1 each  diagonal-complete strobes
- c11, c12, c21, c22  input  ACC_W each  array results
- busy  output  1  state != IDLE

## Operation
- FSM states: IDLE, CLEAR, FEED, RESULT.
- IDLE:
  - in_ready=1.
  - On in_valid, register a_mat/b_mat and go to CLEAR.
- CLEAR: one cycle, array_clr=1, then go to FEED with step counter t=0.
- FEED: counts t=0..4+PIPE_LAT, then goes to RESULT. Operands by step (0 outside the listed steps):
  - t0: a1X=A11, bX1=B11
  - t1: a1X=A12, a2X=A21, bX1=B21, bX2=B12
  - t2: a2X=A22, bX2=B22
  - t>=3: all operands 0
- Push strobes, each exactly one cycle:
  - push11 at t=2+PIPE_LAT, and C11 ← c11 the same cycle.
  - pushedge at t=3+PIPE_LAT, and C12 ← c12, C21 ← c21.
  - push22 at t=4+PIPE_LAT, and C22 ← c22.
- RESULT:
  - out_valid=1 and c_mat stable until out_ready, then go to IDLE.
  - in_ready=0; jobs are never overlapped.
- Arithmetic: no controller arithmetic. Results pass through bit-exact; wrap mod 2^ACC_W is the array's behaviour.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, array_clr=0, all push=0, all operands=0, c_mat=0.
- Latency: in_valid&in_ready edge → out_valid high 7+PIPE_LAT cycles later.
- Minimum job period: 8+PIPE_LAT cycles, including the 1-cycle IDLE gap.
- in_valid held during busy is ignored, not queued. No combinational path from in_valid or out_ready to any output.
- out_ready high in the same cycle out_valid rises: result is consumed on that edge, and the FSM is in IDLE on the next cycle.
- Reset mid-job: immediate return to reset values. array_clr is not asserted by reset; the next job's CLEAR cleans the array.
- a_mat/b_mat changes after acceptance have no effect.

## Configuration
- SYSTOLIC_CTRL_ACCUM_EN
  - Defined: adds input `accum` (1 bit), sampled with the job. accum=1 skips CLEAR (IDLE→FEED directly; latency 6+PIPE_LAT), so the array adds A·B onto the previous accumulators.
  - Undefined: no `accum` port; CLEAR is always executed.

## Structure
- Package `systolic_pkg`:
  - state enum `sctrl_state_t`
  - DATA_W/ACC_W defaults
  - step constants T_PUSH11=2, T_PUSHEDGE=3, T_PUSH22=4
  - unpack helpers for a_mat/b_mat
- Sub-module `sctrl_skew_mux`: combinational step-to-operand selection, isolated so the schedule is reviewable and reusable for larger arrays. The FSM and result capture stay in the top module.

## Test plan
- Reference job:
  - Stimulus: A=[[-6,7],[1,-4]], B=[[-2,0],[9,1]], array instantiated.
  - Required: operand sequence a1X -6,7,0; a2X 0,1,-4; bX1 -2,9,0; bX2 0,0,1. c_mat = {-4,-38,7,75}. out_valid exactly 7 cycles after acceptance.
- Back-pressure:
  - Stimulus: out_ready low for 10 cycles.
  - Required: c_mat/out_valid stable; in_ready=0; a new in_valid is ignored. After out_ready, the next job gives its own correct result.
- Extremes:
  - Stimulus: A=B=all -128.
  - Required: C = 32768 in every element, with no truncation.
- Reset mid-job:
  - Stimulus: reset low at t=1.
  - Required: all outputs return to reset values asynchronously. The following job A=I, B=[[3,4],[5,6]] yields [[3,4],[5,6]].
- PIPE_LAT=2:
  - Required: pushes at t=4,5,6; latency 9; same results as the reference job.
- ACCUM_EN:
  - Stimulus: reference job, then repeat with accum=1.
  - Required: second result {-8,-76,14,150}; no array_clr pulse on the second job.
